// File: rtl/accumulator_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_control_unit_if
// Description : Bus bundle between the accumulator control unit (master) and
//               the surrounding datapath/memory (slave). Carries the unified
//               program/data memory port, the ALU operand/operation/result
//               signals, the registered flags and the status pulses.
//               Ports (master view):
//                 out: mem_addr, mem_rd, mem_wr, mem_wdata, acc, alu_src,
//                      alu_op, update_flags, instr_done, illegal_op, halted
//                 in : mem_rdata, temp_result, zero_flag, sign_flag,
//                      carry_flag
// Revision    : 1.0 - initial release
// ============================================================================
interface accumulator_control_unit_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int ALU_OP_BITS = 4
);
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_rd;
  logic                   mem_wr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic [DATA_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]  alu_src;
  logic [ALU_OP_BITS-1:0] alu_op;
  logic                   update_flags;
  logic [DATA_WIDTH:0]    temp_result;
  logic                   zero_flag;
  logic                   sign_flag;
  logic                   carry_flag;
  logic                   instr_done;
  logic                   illegal_op;
  logic                   halted;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata, acc, alu_src, alu_op,
           update_flags, instr_done, illegal_op, halted,
    input  mem_rdata, temp_result, zero_flag, sign_flag, carry_flag
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata, acc, alu_src, alu_op,
           update_flags, instr_done, illegal_op, halted,
    output mem_rdata, temp_result, zero_flag, sign_flag, carry_flag
  );
endinterface
`default_nettype wire

// File: rtl/accumulator_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_control_unit
// Description : Fetch/decode/execute sequencer for an 8-bit accumulator
//               machine. Owns PC, instruction register, operand register and
//               accumulator; drives the ALU operation and writes the ALU
//               result back into the accumulator. A single memory holds both
//               program and data (registered read: data valid the cycle after
//               mem_rd).
//               Ports:
//                 clk, reset (async, active-high)
//                 bus : accumulator_control_unit_if.master
//                 step_mode, step_go : only with CU_SINGLE_STEP_EN defined
//               Optional feature macro: CU_SINGLE_STEP_EN (single-step WAIT
//               state between instructions).
// Revision    : 1.0 - initial release
// ============================================================================
module accumulator_control_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int ALU_OP_BITS = 4
) (
  input  wire logic clk,
  input  wire logic reset,
`ifdef CU_SINGLE_STEP_EN
  input  wire logic step_mode,
  input  wire logic step_go,
`endif
  accumulator_control_unit_if.master bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_OPERAND = 3'd2;
  localparam logic [2:0] ST_MEMRD   = 3'd3;
  localparam logic [2:0] ST_EXEC    = 3'd4;
  localparam logic [2:0] ST_HALT    = 3'd5;
`ifdef CU_SINGLE_STEP_EN
  localparam logic [2:0] ST_WAIT    = 3'd6;
`endif

  // Instruction classes produced by the opcode decoder
  localparam logic [2:0] CL_UNARY = 3'd0;  // one-byte ALU op
  localparam logic [2:0] CL_IMM   = 3'd1;  // ALU op with immediate byte
  localparam logic [2:0] CL_MEM   = 3'd2;  // ALU op with memory operand
  localparam logic [2:0] CL_ST    = 3'd3;
  localparam logic [2:0] CL_JMP   = 3'd4;
  localparam logic [2:0] CL_NOP   = 3'd5;
  localparam logic [2:0] CL_HLT   = 3'd6;
  localparam logic [2:0] CL_ILL   = 3'd7;

  // --------------------------------------------------------------------------
  // Opcode classification. Opcodes live in the low byte of a memory word.
  // --------------------------------------------------------------------------
  function automatic logic [2:0] classify(input logic [7:0] op);
    logic [3:0] hi;
    logic [3:0] lo;
    logic       lo_unary;
    hi       = op[7:4];
    lo       = op[3:0];
    // INC, DEC, RL, RR and NOT take no operand byte
    lo_unary = (lo >= 4'h3 && lo <= 4'h6) || (lo == 4'hA);
    classify = CL_ILL;
    if (hi == 4'h0 && lo <= 4'hA) begin
      classify = lo_unary ? CL_UNARY : CL_IMM;
    end else if (hi == 4'h1 && lo <= 4'h9 && !(lo >= 4'h3 && lo <= 4'h6)) begin
      classify = CL_MEM;
    end else if (op == 8'h20) begin
      classify = CL_ST;
    end else if (hi == 4'h3 && lo <= 4'h5) begin
      classify = CL_JMP;
    end else if (op == 8'h40) begin
      classify = CL_NOP;
    end else if (op == 8'hFF) begin
      classify = CL_HLT;
    end
  endfunction

  // Jump condition selected by the low bits of the jump opcode
  function automatic logic jump_taken(input logic [2:0] cc,
                                      input logic z, input logic s,
                                      input logic c);
    case (cc)
      3'd0:    jump_taken = 1'b1;  // JMP
      3'd1:    jump_taken = z;     // JZ
      3'd2:    jump_taken = ~z;    // JNZ
      3'd3:    jump_taken = c;     // JC
      3'd4:    jump_taken = ~c;    // JNC
      3'd5:    jump_taken = s;     // JN
      default: jump_taken = 1'b0;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q,    pc_d;
  logic [DATA_WIDTH-1:0] ir_q,    ir_d;
  logic [DATA_WIDTH-1:0] opr_q,   opr_d;
  logic [DATA_WIDTH-1:0] acc_q,   acc_d;
`ifdef CU_SINGLE_STEP_EN
  // Marks the first cycle after reset so step mode can park in WAIT
  logic                  boot_q,  boot_d;
`endif

  // Combinational strobes before reset gating
  logic [ADDR_WIDTH-1:0]  mem_addr_c;
  logic                   mem_rd_c;
  logic                   mem_wr_c;
  logic [ALU_OP_BITS-1:0] alu_op_c;
  logic                   update_flags_c;
  logic                   instr_done_c;
  logic                   illegal_op_c;
  logic [2:0]             decode_cls;
  logic [2:0]             ir_cls;
  logic [2:0]             after_done;

  assign decode_cls = classify(bus.mem_rdata[7:0]);
  assign ir_cls     = classify(ir_q[7:0]);

`ifdef CU_SINGLE_STEP_EN
  assign after_done = step_mode ? ST_WAIT : ST_FETCH;
`else
  assign after_done = ST_FETCH;
`endif

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    opr_d          = opr_q;
    acc_d          = acc_q;
    mem_addr_c     = pc_q;
    mem_rd_c       = 1'b0;
    mem_wr_c       = 1'b0;
    alu_op_c       = '0;
    update_flags_c = 1'b0;
    instr_done_c   = 1'b0;
    illegal_op_c   = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    boot_d         = 1'b0;
`endif

    case (state_q)
      ST_FETCH: begin
`ifdef CU_SINGLE_STEP_EN
        if (boot_q && step_mode) begin
          state_d = ST_WAIT;
        end else begin
          mem_rd_c = 1'b1;
          pc_d     = pc_q + 1'b1;
          state_d  = ST_DECODE;
        end
`else
        mem_rd_c = 1'b1;
        pc_d     = pc_q + 1'b1;
        state_d  = ST_DECODE;
`endif
      end

      ST_DECODE: begin
        // The opcode is decoded straight off the read bus; ir only holds it
        // for the later states.
        ir_d = bus.mem_rdata;
        case (decode_cls)
          CL_UNARY: state_d = ST_EXEC;
          CL_IMM, CL_MEM, CL_ST, CL_JMP: begin
            mem_rd_c = 1'b1;
            pc_d     = pc_q + 1'b1;
            state_d  = ST_OPERAND;
          end
          CL_NOP: begin
            instr_done_c = 1'b1;
            state_d      = after_done;
          end
          CL_HLT: state_d = ST_HALT;
          default: begin
            illegal_op_c = 1'b1;
            instr_done_c = 1'b1;
            state_d      = after_done;
          end
        endcase
      end

      ST_OPERAND: begin
        opr_d = bus.mem_rdata;
        case (ir_cls)
          CL_IMM: state_d = ST_EXEC;
          CL_MEM: begin
            mem_addr_c = bus.mem_rdata[ADDR_WIDTH-1:0];
            mem_rd_c   = 1'b1;
            state_d    = ST_MEMRD;
          end
          CL_ST: begin
            mem_addr_c   = bus.mem_rdata[ADDR_WIDTH-1:0];
            mem_wr_c     = 1'b1;
            instr_done_c = 1'b1;
            state_d      = after_done;
          end
          CL_JMP: begin
            if (jump_taken(ir_q[2:0], bus.zero_flag, bus.sign_flag,
                           bus.carry_flag)) begin
              pc_d = bus.mem_rdata[ADDR_WIDTH-1:0];
            end
            instr_done_c = 1'b1;
            state_d      = after_done;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEMRD: begin
        opr_d   = bus.mem_rdata;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        alu_op_c       = ALU_OP_BITS'(ir_q[3:0]);
        update_flags_c = 1'b1;
        acc_d          = bus.temp_result[DATA_WIDTH-1:0];
        instr_done_c   = 1'b1;
        state_d        = after_done;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

`ifdef CU_SINGLE_STEP_EN
      ST_WAIT: begin
        if (step_go) begin
          state_d = ST_FETCH;
        end
      end
`endif

      default: state_d = ST_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opr_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      acc_q   <= acc_d;
    end
  end

`ifdef CU_SINGLE_STEP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot_q <= 1'b1;
    end else begin
      boot_q <= boot_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs. Strobes are masked while reset is asserted so an instruction
  // interrupted mid-flight (e.g. a store in OPERAND) can never write.
  // --------------------------------------------------------------------------
  assign bus.mem_addr     = reset ? '0 : mem_addr_c;
  assign bus.mem_rd       = mem_rd_c       & ~reset;
  assign bus.mem_wr       = mem_wr_c       & ~reset;
  assign bus.mem_wdata    = acc_q;
  assign bus.acc          = acc_q;
  assign bus.alu_src      = opr_q;
  assign bus.alu_op       = reset ? '0 : alu_op_c;
  assign bus.update_flags = update_flags_c & ~reset;
  assign bus.instr_done   = instr_done_c   & ~reset;
  assign bus.illegal_op   = illegal_op_c   & ~reset;
  assign bus.halted       = (state_q == ST_HALT);

  // The carry bit of the ALU result is consumed by the external flag register
  logic unused_carry;
  assign unused_carry = bus.temp_result[DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_accumulator_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_accumulator_control_unit
// Description : Directed bench for accumulator_control_unit. Provides a
//               256-byte registered-read memory, a behavioural ALU and a
//               flag register around the control unit, then runs short
//               hand-computed programs and checks outputs cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulator_control_unit;

  logic clk;
  logic reset;

  accumulator_control_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ALU_OP_BITS(4)) bus ();

  accumulator_control_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .ALU_OP_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem [0:255];
  logic [7:0] rdata;
  logic       clr;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h40;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rd) rdata <= mem[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata;

  // ---------------- ALU model ----------------
  logic [8:0] alu_res;
  always_comb begin
    alu_res = 9'h000;
    case (bus.alu_op)
      4'h0: alu_res = {1'b0, bus.alu_src};
      4'h1: alu_res = {1'b0, bus.acc} + {1'b0, bus.alu_src};
      4'h2: alu_res = {1'b0, bus.acc} - {1'b0, bus.alu_src};
      4'h3: alu_res = {1'b0, bus.acc} + 9'd1;
      4'h4: alu_res = {1'b0, bus.acc} - 9'd1;
      4'h5: alu_res = {bus.acc[7], bus.acc[6:0], bus.acc[7]};
      4'h6: alu_res = {bus.acc[0], bus.acc[0], bus.acc[7:1]};
      4'h7: alu_res = {1'b0, bus.acc & bus.alu_src};
      4'h8: alu_res = {1'b0, bus.acc | bus.alu_src};
      4'h9: alu_res = {1'b0, bus.acc ^ bus.alu_src};
      4'hA: alu_res = {1'b0, ~bus.acc};
      default: alu_res = 9'h000;
    endcase
  end
  assign bus.temp_result = alu_res;

  // ---------------- flag register ----------------
  logic zf, sf, cf;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      zf <= 1'b0; sf <= 1'b0; cf <= 1'b0;
    end else if (bus.update_flags) begin
      zf <= (alu_res[7:0] == 8'h00);
      sf <= alu_res[7];
      cf <= alu_res[8];
    end
  end
  assign bus.zero_flag  = zf;
  assign bus.sign_flag  = sf;
  assign bus.carry_flag = cf;

  // ---------------- event monitors ----------------
  int done_cnt = 0;
  int ill_cnt  = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (bus.instr_done) done_cnt++;
    if (bus.illegal_op) ill_cnt++;
    if (bus.mem_wr)     wr_cnt++;
    if (bus.mem_rd && bus.mem_wr) both_cnt++;
  end

  // ---------------- check helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Enter reset, clear memory to NOPs; caller then loads bytes.
  task automatic begin_test();
    reset = 1'b1;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Release reset just after a rising edge; returns at the negedge of the
  // first post-reset cycle (cycle 0, FETCH).
  task automatic go();
    reset = 1'b0;
    @(negedge clk);
  endtask

  int d0, w0, i0;

  initial begin
    reset = 1'b1; clr = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // ---------------- reset state ----------------
    begin_test();
    @(negedge clk);
    check("rst_acc",    {24'd0, bus.acc},      32'h00);
    check("rst_rd",     {31'd0, bus.mem_rd},   32'h0);
    check("rst_wr",     {31'd0, bus.mem_wr},   32'h0);
    check("rst_addr",   {24'd0, bus.mem_addr}, 32'h00);
    check("rst_halted", {31'd0, bus.halted},   32'h0);
    check("rst_done",   {31'd0, bus.instr_done}, 32'h0);
    check("rst_alu_op", {28'd0, bus.alu_op},   32'h0);
    @(posedge clk); #1;

    // ---------------- LDI 5 ; ADD 3 ; HLT ----------------
    put_byte(8'h00, 8'h00); put_byte(8'h01, 8'h05);
    put_byte(8'h02, 8'h01); put_byte(8'h03, 8'h03);
    put_byte(8'h04, 8'hFF);
    go();
    d0 = done_cnt;
    check("p1_c0_rd",   {31'd0, bus.mem_rd},   32'h1);
    check("p1_c0_addr", {24'd0, bus.mem_addr}, 32'h00);
    tick(3);
    check("p1_ldi_done", {31'd0, bus.instr_done},   32'h1);
    check("p1_ldi_upd",  {31'd0, bus.update_flags}, 32'h1);
    tick(1);
    check("p1_add_fetch", {24'd0, bus.mem_addr}, 32'h02);
    tick(3);
    check("p1_add_done", {31'd0, bus.instr_done}, 32'h1);
    check("p1_add_op",   {28'd0, bus.alu_op},     32'h1);
    tick(3);
    check("p1_halted",  {31'd0, bus.halted},   32'h1);
    check("p1_acc",     {24'd0, bus.acc},      32'h08);
    check("p1_pc",      {24'd0, dut.pc_q},     32'h05);
    check("p1_ndone",   done_cnt - d0,         32'd2);
    tick(2);
    check("p1_halt_rd", {31'd0, bus.mem_rd},   32'h0);
    check("p1_halt_hold", {31'd0, bus.halted}, 32'h1);

    // ---------------- LDI FF ; INC ; JZ 20 ----------------
    begin_test();
    put_byte(8'h00, 8'h00); put_byte(8'h01, 8'hFF);
    put_byte(8'h02, 8'h03);
    put_byte(8'h03, 8'h31); put_byte(8'h04, 8'h20);
    go();
    tick(6);
    check("p2_inc_op",  {28'd0, bus.alu_op},       32'h3);
    check("p2_inc_upd", {31'd0, bus.update_flags}, 32'h1);
    tick(1);
    check("p2_acc",   {24'd0, bus.acc},      32'h00);
    check("p2_zero",  {31'd0, bus.zero_flag},  32'h1);
    check("p2_carry", {31'd0, bus.carry_flag}, 32'h1);
    check("p2_jz_fetch", {24'd0, bus.mem_addr}, 32'h03);
    tick(2);
    check("p2_jz_done", {31'd0, bus.instr_done},   32'h1);
    check("p2_jz_upd",  {31'd0, bus.update_flags}, 32'h0);
    tick(1);
    check("p2_target_addr", {24'd0, bus.mem_addr}, 32'h20);
    check("p2_target_rd",   {31'd0, bus.mem_rd},   32'h1);

    // ---------------- LDI A5 ; ST 80 ; LDI 0 ; LD 80 ----------------
    begin_test();
    put_byte(8'h00, 8'h00); put_byte(8'h01, 8'hA5);
    put_byte(8'h02, 8'h20); put_byte(8'h03, 8'h80);
    put_byte(8'h04, 8'h00); put_byte(8'h05, 8'h00);
    put_byte(8'h06, 8'h10); put_byte(8'h07, 8'h80);
    go();
    w0 = wr_cnt;
    tick(6);
    check("p3_st_wr",    {31'd0, bus.mem_wr},    32'h1);
    check("p3_st_addr",  {24'd0, bus.mem_addr},  32'h80);
    check("p3_st_data",  {24'd0, bus.mem_wdata}, 32'hA5);
    check("p3_st_nord",  {31'd0, bus.mem_rd},    32'h0);
    tick(5);
    check("p3_acc_cleared", {24'd0, bus.acc}, 32'h00);
    tick(2);
    check("p3_ld_rd",   {31'd0, bus.mem_rd},   32'h1);
    check("p3_ld_addr", {24'd0, bus.mem_addr}, 32'h80);
    tick(2);
    check("p3_ld_done", {31'd0, bus.instr_done}, 32'h1);
    check("p3_ld_op",   {28'd0, bus.alu_op},     32'h0);
    tick(1);
    check("p3_acc",   {24'd0, bus.acc},  32'hA5);
    check("p3_mem80", {24'd0, mem[8'h80]}, 32'hA5);
    check("p3_nwr",   wr_cnt - w0,       32'd1);

    // ---------------- LDI 0 ; JNZ 40 (not taken) ----------------
    begin_test();
    put_byte(8'h00, 8'h00); put_byte(8'h01, 8'h00);
    put_byte(8'h02, 8'h32); put_byte(8'h03, 8'h40);
    go();
    tick(6);
    check("p4_jnz_done", {31'd0, bus.instr_done},   32'h1);
    check("p4_jnz_upd",  {31'd0, bus.update_flags}, 32'h0);
    tick(1);
    check("p4_next_addr", {24'd0, bus.mem_addr},  32'h04);
    check("p4_zero_kept", {31'd0, bus.zero_flag}, 32'h1);

    // ---------------- LDI 3C ; illegal 77 ----------------
    begin_test();
    put_byte(8'h00, 8'h00); put_byte(8'h01, 8'h3C);
    put_byte(8'h02, 8'h77);
    go();
    i0 = ill_cnt;
    tick(5);
    check("p5_ill",      {31'd0, bus.illegal_op}, 32'h1);
    check("p5_ill_done", {31'd0, bus.instr_done}, 32'h1);
    tick(1);
    check("p5_ill_low",  {31'd0, bus.illegal_op}, 32'h0);
    check("p5_next_addr", {24'd0, bus.mem_addr},  32'h03);
    check("p5_acc",      {24'd0, bus.acc},        32'h3C);
    tick(1);
    check("p5_nill",     ill_cnt - i0,            32'd1);

    // ---------------- reset during EXEC of ADD ----------------
    begin_test();
    put_byte(8'h00, 8'h00); put_byte(8'h01, 8'h05);
    put_byte(8'h02, 8'h01); put_byte(8'h03, 8'h03);
    go();
    tick(7);
    check("p6_in_exec", {28'd0, bus.alu_op}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("p6_acc",  {24'd0, bus.acc},      32'h00);
    check("p6_pc",   {24'd0, dut.pc_q},     32'h00);
    check("p6_wr",   {31'd0, bus.mem_wr},   32'h0);
    check("p6_upd",  {31'd0, bus.update_flags}, 32'h0);
    @(posedge clk); #1;
    go();
    check("p6_rd",   {31'd0, bus.mem_rd},   32'h1);
    check("p6_addr", {24'd0, bus.mem_addr}, 32'h00);

    // ---------------- reset during OPERAND of ST ----------------
    begin_test();
    put_byte(8'h00, 8'h00); put_byte(8'h01, 8'hA5);
    put_byte(8'h02, 8'h20); put_byte(8'h03, 8'h80);
    put_byte(8'h80, 8'h11);
    go();
    w0 = wr_cnt;
    tick(5);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("p7_wr", {31'd0, bus.mem_wr}, 32'h0);
    tick(2);
    check("p7_mem80", {24'd0, mem[8'h80]}, 32'h11);
    check("p7_nwr",   wr_cnt - w0,         32'd0);
    check("p7_acc",   {24'd0, bus.acc},    32'h00);
    @(posedge clk); #1;
    go();
    check("p7_rd",   {31'd0, bus.mem_rd},   32'h1);
    check("p7_addr", {24'd0, bus.mem_addr}, 32'h00);

    // rd and wr must never coincide anywhere in the run
    check("rd_wr_exclusive", both_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accumulator_control_unit.md
Name: accumulator_control_unit

Overview:
- Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
- Owns PC, instruction register, operand register and accumulator.
- Drives alu_op, the ALU src operand and update_flags; writes back temp_result into the accumulator.
- Reads the registered zero/sign/carry flags to resolve conditional jumps. Single memory holds both program and data.

Parameters:
DATA_WIDTH, 8, accumulator/operand/memory data width
ADDR_WIDTH, 8, PC and memory address width
ALU_OP_BITS, 4, width of alu_op encoding

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
mem_addr  output  ADDR_WIDTH  memory address
mem_rd  output  1  read strobe; mem_rdata valid the following cycle
mem_wr  output  1  write strobe, one cycle
mem_wdata  output  DATA_WIDTH  write data (= acc)
mem_rdata  input  DATA_WIDTH  read data
acc  output  DATA_WIDTH  accumulator, feeds ALU acc input
alu_src  output  DATA_WIDTH  operand register, feeds ALU src input
alu_op  output  ALU_OP_BITS  ALU operation (PASS=0 ADD=1 SUB=2 INC=3 DEC=4 RL=5 RR=6 AND=7 OR=8 XOR=9 NOT=A)
update_flags  output  1  flag register update enable
temp_result  input  DATA_WIDTH+1  ALU result incl. carry
zero_flag, sign_flag, carry_flag  input  1 each  registered flags
instr_done  output  1  one-cycle pulse on instruction completion
illegal_op  output  1  one-cycle pulse on undefined opcode
halted  output  1  high in HALT state

Behaviour:
- Reset (async, active-high): pc=0, ir=0, opr=0, acc=0, state=FETCH. All strobes, instr_done, illegal_op, halted = 0; alu_op=0; mem_addr=0. Reset mid-instruction aborts it with no write.
- ISA (byte opcodes):
  - 0x00-0x0A: ALU op = low nibble, immediate. Ops 3,4,5,6,A are one-byte; others are two-byte (imm follows).
  - 0x10-0x19 (low nibble excluding 3..6): ALU op with memory operand; second byte = address. 0x10 = LD.
  - 0x20 addr: ST.
  - 0x30 JMP, 0x31 JZ, 0x32 JNZ, 0x33 JC, 0x34 JNC, 0x35 JN (sign=1); second byte = target.
  - 0x40: NOP. 0xFF: HLT. All other opcodes: illegal_op pulse, then execute as one-byte NOP.
- FSM states FETCH, DECODE, OPERAND, MEMRD, EXEC, HALT:
  - FETCH: mem_addr=pc, mem_rd=1, pc<=pc+1. Next state DECODE.
  - DECODE: ir<=mem_rdata. One-byte ALU op → EXEC. NOP/illegal → FETCH with instr_done. HLT → HALT. Two-byte: mem_addr=pc, mem_rd=1, pc<=pc+1, next state OPERAND.
  - OPERAND: opr<=mem_rdata (the operand byte). Then:
    - Immediate ALU → EXEC.
    - Memory ALU: mem_addr=mem_rdata, mem_rd=1, next state MEMRD.
    - ST: mem_addr=mem_rdata, mem_wr=1, mem_wdata=acc, instr_done, next state FETCH.
    - Jump: pc<=mem_rdata if condition true, else unchanged; instr_done; next state FETCH.
  - MEMRD: opr<=mem_rdata. Next state EXEC.
  - EXEC: alu_op=ir[3:0], update_flags=1, acc<=temp_result[DATA_WIDTH-1:0], instr_done. Next state FETCH.
  - HALT: halted=1, no memory access. Leaves only via reset.
- Instruction latency in cycles: unary 3, immediate 4, memory ALU 5, ST 3, jump 3, NOP 2.
- alu_op=0 and update_flags=0 outside EXEC. alu_src=opr at all times.
- Flag-setting: every ALU-class instruction (including LDI/LD) updates flags. ST, jumps and NOP do not. Flags written in EXEC are visible to any following jump (≥2 cycles later).
- PC wraps modulo 2^ADDR_WIDTH; an operand byte at address 0xFF is fetched from 0x00.
- mem_rd and mem_wr are never high in the same cycle.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- Defined: adds input ports step_mode and step_go. When step_mode=1, the FSM enters a WAIT state instead of FETCH after each instr_done (and after reset). WAIT advances to FETCH on the cycle step_go=1; step_go is ignored in all other states. When step_mode=0, WAIT is never entered.
- Undefined: ports and WAIT state are absent; free-running behaviour as above.

Test Plan:
- Program 00 05, 01 03, FF; flags clear → acc=0x08, halted=1, pc=0x05, two instr_done pulses; ADD completes 4 cycles after its FETCH.
- 00 FF, 03, 31 20 → INC yields acc=0x00, zero=1, carry=1; JZ taken, next FETCH at mem_addr=0x20.
- 00 A5, 20 80, 00 00, 10 80 → single-cycle mem_wr at 0x80 with data 0xA5; final acc=0xA5 after the 5-cycle LD.
- JNZ 32 40 with zero=1 → not taken, pc advances by 2, no flag update.
- Opcode 0x77 → illegal_op single pulse, instruction acts as NOP, pc+1, acc unchanged.
- Reset asserted during EXEC of ADD, and separately during OPERAND of ST → acc=0, pc=0, no mem_wr, first post-reset mem_rd at address 0x00.
